// File: rtl/wave_meter.sv
// wave_meter: hysteresis rising-crossing detector measuring period, high time and peaks
// of a signed sample stream, with a hold-until-accepted result, timeout and overrun flags.
module wave_meter #(
  parameter int M = 16,
  parameter int P = 24,
  parameter int H = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [M-1:0] sample,
  input  logic                sample_valid,
  input  logic                result_ready,
  output logic                result_valid,
  output logic [P-1:0]        period,
  output logic [P-1:0]        high_count,
  output logic signed [M-1:0] peak_max,
  output logic signed [M-1:0] peak_min,
  output logic                timeout,
  output logic                overrun
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic signed [M-1:0] H_POS = M'(H);
  localparam logic signed [M-1:0] H_NEG = -H_POS;
  state_t state_q, state_d;
  logic armed_q, armed_d;
  logic [P-1:0] cnt_q, cnt_d, high_q, high_d, period_q, period_d, hc_q, hc_d;
  logic signed [M-1:0] max_q, max_d, min_q, min_d, pmax_q, pmax_d, pmin_q, pmin_d;
  logic rv_q, rv_d, to_q, to_d, ov_q, ov_d;
  logic crossing, emit, is_pos;
  logic [P-1:0] cnt_inc;
  always_comb begin
    crossing = sample_valid && armed_q && (sample >= H_POS);
    emit     = crossing && (state_q == MEASURE);
    is_pos   = !sample[M-1];
    cnt_inc  = cnt_q + P'(1);
    state_d  = state_q;
    armed_d  = sample_valid ? (crossing ? 1'b0 : (sample < H_NEG) ? 1'b1 : armed_q) : armed_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    max_d    = max_q;
    min_d    = min_q;
    to_d     = to_q;
    period_d = emit ? cnt_q : period_q;
    hc_d     = emit ? high_q : hc_q;
    pmax_d   = emit ? max_q : pmax_q;
    pmin_d   = emit ? min_q : pmin_q;
    rv_d     = emit || (rv_q && !result_ready);
    ov_d     = ov_q || (emit && rv_q && !result_ready);
    if (crossing) begin
      state_d = MEASURE;
      cnt_d   = P'(1);
      high_d  = P'(is_pos);
      max_d   = sample;
      min_d   = sample;
      to_d    = (state_q == IDLE) ? 1'b0 : to_q;
    end else if (sample_valid && state_q == MEASURE) begin
      cnt_d   = cnt_inc;
      high_d  = high_q + P'(is_pos);
      max_d   = (sample > max_q) ? sample : max_q;
      min_d   = (sample < min_q) ? sample : min_q;
      // counter saturation abandons the measurement; armed is left as is
      state_d = (&cnt_inc) ? IDLE : MEASURE;
      to_d    = (&cnt_inc) ? 1'b1 : to_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      high_q   <= '0;
      max_q    <= '0;
      min_q    <= '0;
      period_q <= '0;
      hc_q     <= '0;
      pmax_q   <= '0;
      pmin_q   <= '0;
      rv_q     <= 1'b0;
      to_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      max_q    <= max_d;
      min_q    <= min_d;
      period_q <= period_d;
      hc_q     <= hc_d;
      pmax_q   <= pmax_d;
      pmin_q   <= pmin_d;
      rv_q     <= rv_d;
      to_q     <= to_d;
      ov_q     <= ov_d;
    end
  end
  assign result_valid = rv_q;
  assign period       = period_q;
  assign high_count   = hc_q;
  assign peak_max     = pmax_q;
  assign peak_min     = pmin_q;
  assign timeout      = to_q;
  assign overrun      = ov_q;
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: table-driven directed vectors for wave_meter plus a P=8 timeout sequence.
module tb_wave_meter;
  logic clk = 1'b0;
  logic rst, sample_valid, result_ready;
  logic signed [15:0] sample;
  logic rv, to, ov, rv8, to8, ov8;
  logic [23:0] per, hc;
  logic [7:0] per8, hc8;
  logic signed [15:0] mx, mn, mx8, mn8;
  always #5 clk = ~clk;
  wave_meter dut (.clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .result_ready(result_ready), .result_valid(rv), .period(per), .high_count(hc),
    .peak_max(mx), .peak_min(mn), .timeout(to), .overrun(ov));
  wave_meter #(.P(8)) dut8 (.clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .result_ready(result_ready), .result_valid(rv8), .period(per8), .high_count(hc8),
    .peak_max(mx8), .peak_min(mn8), .timeout(to8), .overrun(ov8));
  typedef struct {
    logic r, v, rdy, rv, to, ov;
    logic signed [15:0] s, mx, mn;
    logic [23:0] per, hc;
  } vec_t;
  vec_t vq[$];
  logic [23:0] e_per, e_hc;
  logic signed [15:0] e_mx, e_mn;
  logic e_ov;
  int n_vec = 0, n_bad = 0;
  task automatic set_res(input int p, h, a, b);
    e_per = 24'(p); e_hc = 24'(h); e_mx = 16'(a); e_mn = 16'(b);
  endtask
  task automatic push(input logic r, v, input int s, input logic rdy, rv_e);
    vec_t x;
    x.r = r; x.v = v; x.s = 16'(s); x.rdy = rdy; x.rv = rv_e; x.to = 1'b0; x.ov = e_ov;
    x.per = e_per; x.hc = e_hc; x.mx = e_mx; x.mn = e_mn;
    vq.push_back(x);
  endtask
  task automatic do_rst();
    set_res(0, 0, 0, 0);
    e_ov = 1'b0;
    push(1, 0, 0, 1, 0);
  endtask
  task automatic negs(input int n, input logic rdy, rv_e);
    for (int i = 0; i < n; i++) push(0, 1, -1000, rdy, rv_e);
  endtask
  task automatic poss(input int n, input logic rdy, rv_e);
    for (int i = 0; i < n; i++) push(0, 1, 1000, rdy, rv_e);
  endtask
  task automatic chk(input string name, input logic [63:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask
  task automatic drive8(input int s);
    rst = 1'b0; sample_valid = 1'b1; sample = 16'(s); result_ready = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    int tri_w[8] = '{-200, -100, 0, 100, 200, 100, 0, -100};
    rst = 1'b1; sample_valid = 1'b0; sample = '0; result_ready = 1'b1;
    e_ov = 1'b0;
    set_res(0, 0, 0, 0);
    // square wave, continuous valid
    do_rst();
    negs(7, 1, 0);
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 10; s++) begin
        if (p >= 1 && s == 0) set_res(10, 3, 1000, -1000);
        push(0, 1, (s < 3) ? 1000 : -1000, 1, (p >= 1 && s == 0));
      end
    // same wave with invalid gaps carrying a large sample
    do_rst();
    for (int i = 0; i < 7; i++) begin push(0, 1, -1000, 1, 0); push(0, 0, 30000, 1, 0); end
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 10; s++) begin
        if (p >= 1 && s == 0) set_res(10, 3, 1000, -1000);
        push(0, 1, (s < 3) ? 1000 : -1000, 1, (p >= 1 && s == 0));
        push(0, 0, 30000, 1, 0);
      end
    // small triangle never arms
    do_rst();
    for (int i = 0; i < 40; i++) push(0, 1, tri_w[i % 8], 1, 0);
    // exact thresholds: -H does not arm, +H crosses when armed
    do_rst();
    push(0, 1, -256, 1, 0); push(0, 1, 256, 1, 0); push(0, 1, -256, 1, 0);
    push(0, 1, -257, 1, 0); push(0, 1, 256, 1, 0); push(0, 1, -257, 1, 0);
    set_res(2, 1, 256, -257);
    push(0, 1, 256, 1, 1);
    // result consumed in the same cycle a new one is loaded
    do_rst();
    negs(7, 0, 0); poss(3, 0, 0); negs(7, 0, 0);
    set_res(10, 3, 1000, -1000);
    poss(3, 0, 1); negs(7, 0, 1);
    poss(1, 1, 1);
    push(0, 0, 0, 1, 0);
    // ready held low across two periods
    do_rst();
    negs(7, 0, 0); poss(3, 0, 0); negs(7, 0, 0);
    set_res(10, 3, 1000, -1000);
    for (int i = 0; i < 2; i++) push(0, 1, 500, 0, 1);
    for (int i = 0; i < 9; i++) push(0, 1, -700, 0, 1);
    set_res(11, 2, 500, -700);
    e_ov = 1'b1;
    poss(1, 0, 1);
    push(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0);
    // reset mid-period, sample during reset ignored
    do_rst();
    negs(7, 1, 0); poss(3, 1, 0); negs(7, 1, 0);
    set_res(10, 3, 1000, -1000);
    poss(1, 1, 1); poss(1, 1, 0); negs(3, 1, 0);
    set_res(0, 0, 0, 0);
    push(1, 1, -1000, 1, 0);
    poss(1, 1, 0);
    negs(7, 1, 0); poss(3, 1, 0); negs(7, 1, 0);
    set_res(10, 3, 1000, -1000);
    poss(1, 1, 1);
    foreach (vq[k]) begin
      rst = vq[k].r; sample_valid = vq[k].v; sample = vq[k].s; result_ready = vq[k].rdy;
      @(posedge clk); #1;
      n_vec++;
      if ({rv, per, hc, mx, mn, to, ov} !== {vq[k].rv, vq[k].per, vq[k].hc, vq[k].mx, vq[k].mn, vq[k].to, vq[k].ov}) begin
        n_bad++;
        $display("FAIL vec%0d: got rv=%0b per=%0d hc=%0d max=%0d min=%0d to=%0b ov=%0b required rv=%0b per=%0d hc=%0d max=%0d min=%0d to=%0b ov=%0b",
          k, rv, per, hc, mx, mn, to, ov, vq[k].rv, vq[k].per, vq[k].hc, vq[k].mx, vq[k].mn, vq[k].to, vq[k].ov);
      end
    end
    // P=8 timeout, recovery, and crossing on the saturating sample
    rst = 1'b1; sample_valid = 1'b0; @(posedge clk); #1;
    drive8(-1000); drive8(1000);
    repeat (253) drive8(500);
    chk("to8_before_sat", 64'(to8), 64'(0));
    drive8(500);
    chk("to8_at_sat", 64'(to8), 64'(1));
    chk("rv8_at_sat", 64'(rv8), 64'(0));
    drive8(-1000);
    chk("to8_held", 64'(to8), 64'(1));
    drive8(1000);
    chk("to8_cleared", 64'(to8), 64'(0));
    chk("rv8_first_cross", 64'(rv8), 64'(0));
    repeat (253) drive8(-1000);
    drive8(1000);
    chk("rv8_sat_cross", 64'(rv8), 64'(1));
    chk("per8_sat_cross", 64'(per8), 64'(254));
    chk("hc8_sat_cross", 64'(hc8), 64'(1));
    chk("max8_sat_cross", 64'(mx8), 64'(16'sd1000));
    chk("min8_sat_cross", 64'(mn8), 64'(16'(-1000)));
    chk("to8_sat_cross", 64'(to8), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
